// File: rtl/encoder_pkg.sv
// Shared types and widths for the 4:2 encoder stage.
package encoder_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEL_W  = 2;

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4:2 priority encoder; highest set bit wins, flags non-one-hot codes.
module prio_enc4
  import encoder_pkg::*;
(
  input  logic [CODE_W-1:0] y,
  output logic [SEL_W-1:0]  sel,
  output logic              err
);

  always_comb begin
    sel = '0;
    priority casez (y)
      4'b1???: sel = 2'b11;
      4'b01??: sel = 2'b10;
      4'b001?: sel = 2'b01;
      default: sel = 2'b00;
    endcase
  end

  // Clearing the lowest set bit leaves something behind iff two or more bits are set.
  always_comb begin
    err = (y == '0) || ((y & (y - CODE_W'(1))) != '0);
  end

endmodule

// File: rtl/encoder4to2_stage.sv
// One-entry registered 4:2 encoder stage with valid/ready on both sides and
// saturating counters of accepted good and bad codes.
module encoder4to2_stage
  import encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] y,
  input  logic              y_valid,
  output logic              y_ready,
  output logic              a,
  output logic              b,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [SEL_W-1:0]   enc_sel;
  logic               enc_err;
  logic               accept;

  prio_enc4 u_prio_enc4 (
    .y   (y),
    .sel (enc_sel),
    .err (enc_err)
  );

  assign accept = y_valid && y_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (y_valid) state_d = FULL;
      FULL:  if (out_ready && !y_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == FULL);
    y_ready   = (state_q != FULL) || out_ready;
  end

  // Result register and counters: only accepted codes update them.
  always_comb begin
    sel_d     = sel_q;
    err_d     = err_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      sel_d = enc_sel;
      err_d = enc_err;
      if (enc_err) begin
        if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        if (ok_cnt_q != CntMax) ok_cnt_d = ok_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      err_q     <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      err_q     <= err_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign a       = sel_q[1];
  assign b       = sel_q[0];
  assign err     = err_q;
  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_encoder4to2_stage.sv
// Randomised and directed bench for encoder4to2_stage: a default-width and a
// 2-bit-counter instance share stimulus and are checked against one model.
module tb_encoder4to2_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] y = 4'b0;
  logic       y_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       y_ready8, a8, b8, err8, ov8;
  logic [7:0] ok8, bad8;
  logic       y_ready2, a2, b2, err2, ov2;
  logic [1:0] ok2, bad2;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  encoder4to2_stage #(.CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready8),
    .a         (a8),
    .b         (b8),
    .err       (err8),
    .out_valid (ov8),
    .out_ready (out_ready),
    .ok_cnt    (ok8),
    .err_cnt   (bad8)
  );

  encoder4to2_stage #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready2),
    .a         (a2),
    .b         (b2),
    .err       (err2),
    .out_valid (ov2),
    .out_ready (out_ready),
    .ok_cnt    (ok2),
    .err_cnt   (bad2)
  );

  // Behavioural model: a held slot plus unbounded event counts.
  bit         m_full = 1'b0;
  logic [1:0] m_sel  = 2'b00;
  bit         m_err  = 1'b0;
  int         m_ok   = 0;
  int         m_bad  = 0;

  always @(posedge clk) begin
    int hi;
    bit bad;
    if (rst) begin
      m_full <= 1'b0;
      m_sel  <= 2'b00;
      m_err  <= 1'b0;
      m_ok   <= 0;
      m_bad  <= 0;
    end else if (y_valid && (!m_full || out_ready)) begin
      hi = 0;
      for (int i = 0; i < 4; i++) if (y[i]) hi = i;
      bad = ($countones(y) != 1);
      m_full <= 1'b1;
      m_sel  <= hi[1:0];
      m_err  <= bad;
      if (bad) m_bad <= m_bad + 1;
      else     m_ok  <= m_ok + 1;
    end else if (out_ready) begin
      m_full <= 1'b0;
    end
  end

  function automatic int sat(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("y_ready8",  int'(y_ready8), int'(!m_full || out_ready));
      check("y_ready2",  int'(y_ready2), int'(!m_full || out_ready));
      check("out_valid8", int'(ov8), int'(m_full));
      check("out_valid2", int'(ov2), int'(m_full));
      check("ab8",  int'({a8, b8}), int'(m_sel));
      check("ab2",  int'({a2, b2}), int'(m_sel));
      check("err8", int'(err8), int'(m_err));
      check("err2", int'(err2), int'(m_err));
      check("ok_cnt8",  int'(ok8),  sat(m_ok, 8));
      check("ok_cnt2",  int'(ok2),  sat(m_ok, 2));
      check("err_cnt8", int'(bad8), sat(m_bad, 8));
      check("err_cnt2", int'(bad2), sat(m_bad, 2));
    end
  end

  // Inputs set just after a rising edge take effect at the following edge.
  task automatic cyc(input bit v, input logic [3:0] yy, input bit ordy, input bit r);
    @(posedge clk);
    #1;
    y_valid   = v;
    y         = yy;
    out_ready = ordy;
    rst       = r;
  endtask

  initial begin
    int sat_exp [6] = '{1, 2, 3, 3, 3, 3};
    logic [3:0] code;

    cyc(0, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(ov8), 0);
    check("rst_y_ready", int'(y_ready8), 1);
    check("rst_ok_cnt", int'(ok8), 0);

    // Decoder loop-back
    cyc(1, 4'b0001, 1, 0);
    cyc(1, 4'b0010, 1, 0);
    @(negedge clk); check("lb0_ab", int'({a8, b8}), 0);
    cyc(1, 4'b0100, 1, 0);
    @(negedge clk); check("lb1_ab", int'({a8, b8}), 1);
    cyc(1, 4'b1000, 1, 0);
    @(negedge clk); check("lb2_ab", int'({a8, b8}), 2);
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk);
    check("lb3_ab", int'({a8, b8}), 3);
    check("lb3_err", int'(err8), 0);
    check("lb_ok_cnt", int'(ok8), 4);

    // Invalid codes
    cyc(1, 4'b0000, 1, 0);
    cyc(1, 4'b1010, 1, 0);
    @(negedge clk); check("inv0_aberr", int'({a8, b8, err8}), 3'b001);
    cyc(1, 4'b1111, 1, 0);
    @(negedge clk); check("inv1_aberr", int'({a8, b8, err8}), 3'b111);
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk);
    check("inv2_aberr", int'({a8, b8, err8}), 3'b111);
    check("inv_err_cnt", int'(bad8), 3);
    check("inv_ok_cnt", int'(ok8), 4);

    // Backpressure
    cyc(1, 4'b0100, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'b0001, 0, 0);
      @(negedge clk);
      check("bp_y_ready", int'(y_ready8), 0);
      check("bp_ab", int'({a8, b8}), 2);
      check("bp_ok_cnt", int'(ok8), 5);
    end
    cyc(1, 4'b0001, 1, 0);
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk);
    check("bp_release_ab", int'({a8, b8}), 0);
    check("bp_release_ok", int'(ok8), 6);

    // Saturation of the 2-bit counter
    cyc(0, 4'b0000, 1, 1);
    code = 4'b0001;
    cyc(1, code, 1, 0);
    for (int i = 0; i < 6; i++) begin
      code = {code[2:0], code[3]};
      cyc((i < 5), code, 1, 0);
      @(negedge clk);
      check("sat_ok_cnt2", int'(ok2), sat_exp[i]);
    end

    // Reset while holding a result under backpressure
    cyc(1, 4'b1000, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    @(negedge clk);
    check("pre_rst_full", int'({ov8, a8, b8}), 3'b111);
    cyc(1, 4'b0001, 0, 1);
    cyc(0, 4'b0000, 0, 0);
    @(negedge clk);
    check("post_rst_out_valid", int'(ov8), 0);
    check("post_rst_y_ready", int'(y_ready8), 1);
    check("post_rst_cnts", int'({ok8, bad8}), 0);

    // Bubble
    cyc(1, 4'b0010, 1, 0);
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk); check("bub0_ov", int'(ov8), 1);
    cyc(1, 4'b0100, 1, 0);
    @(negedge clk); check("bub1_ov", int'(ov8), 0);
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk); check("bub2_ov", int'(ov8), 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) code = 4'b0001 << $urandom_range(0, 3);
      else code = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 3) != 0), code, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 60) == 0));
    end
    cyc(0, 4'b0000, 1, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encoder4to2_stage.md
# encoder4to2_stage

Registered 4:2 priority encoder with a valid/ready handshake on both sides; the reverse direction of the 2:4 decoder. It converts a one-hot 4-bit code `y` back into the select pair `{a, b}`, flags non-one-hot codes, and keeps saturating counts of good and bad codes. It is intended for loop-back checking of the decoder and as a standalone one-entry pipeline stage.

## Interface
- `CNT_W`, default 8: width of each saturating event counter; legal range 2 to 16.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous active-high reset.
- `y`, input, 4: one-hot code. Bit `i` set means select value `i`.
- `y_valid`, input, 1: `y` is presented.
- `y_ready`, output, 1: stage can accept a code this cycle.
- `a`, output, 1: MSB of the encoded select.
- `b`, output, 1: LSB of the encoded select.
- `err`, output, 1: the held code was not one-hot. Qualified by `out_valid`.
- `out_valid`, output, 1: `{a, b, err}` holds a result.
- `out_ready`, input, 1: downstream consumes the result.
- `ok_cnt`, output, `CNT_W`: count of accepted one-hot codes, saturating.
- `err_cnt`, output, `CNT_W`: count of accepted non-one-hot codes, saturating.

## Operation
- **Encoding**, highest set bit wins:
  - `1xxx` gives `{a, b} = 11`.
  - `01xx` gives `10`.
  - `001x` gives `01`.
  - `0001` gives `00`.
  - `0000` gives `00`.
- **Error flag:** `err = 1` when `y` is zero or has two or more bits set.
- **States:** two-state FSM, `EMPTY` and `FULL`.
  - `EMPTY`: `out_valid = 0`. If `y_valid`, capture and go to `FULL`.
  - `FULL`: `out_valid = 1`.
    - If `out_ready` and `y_valid`, capture the new code and stay in `FULL`.
    - If `out_ready` and not `y_valid`, go to `EMPTY`.
    - If not `out_ready`, hold all outputs stable.
- **Ready:** `y_ready = !out_valid || out_ready`. This is combinational from `out_ready`; there is no path from `y_valid` to `y_ready`.
- **Accept:** an input is accepted when `y_valid && y_ready`. Only accepted codes are encoded and counted.
- **Counters:**
  - On accept, `ok_cnt` increments if `err = 0`; otherwise `err_cnt` increments.
  - Each counter saturates at `2^CNT_W - 1` and never wraps.
  - Counters are not affected by the output handshake.
- **Reset values:** `a = 0`, `b = 0`, `err = 0`, `out_valid = 0`, `ok_cnt = 0`, `err_cnt = 0`, state `EMPTY`. `y_ready` is therefore 1 in the cycle after reset deasserts.
- **Reset mid-operation:** a held result is discarded, not delivered, and counters clear. `rst` overrides every simultaneous handshake.
- **Input protocol:** the upstream must hold `y` stable while `y_valid = 1` and `y_ready = 0`. The block does not check this.

## Timing
- **Latency:** code accepted at edge N appears on `{a, b, err}` with `out_valid = 1` after edge N.
- **Counter update:** the counter change from an accept at edge N is visible after edge N.
- **Throughput:** one code per cycle while `out_ready = 1`.
- **Bubble:** in `EMPTY` with `y_valid = 0`, `out_valid` stays 0 and the output data holds its previous value.
- **Backpressure:** with `out_ready = 0` in `FULL`, `y_ready = 0` and the stage holds indefinitely.
- **Register boundaries:** all outputs except `y_ready` come straight from registers.

## Structure
- **Shared package `encoder_pkg`:**
  - `state_t` enum (`EMPTY`, `FULL`).
  - Constant `CODE_W = 4`.
  - Constant `SEL_W = 2`.
- **Sub-module `prio_enc4`:** purely combinational; `y[3:0]` in, `sel[1:0]` and `err` out. The top level contains the FSM, the output register and the counters.

## Test plan
1. **Decoder loop-back:** drive `y = 0001, 0010, 0100, 1000` on consecutive cycles with `out_ready = 1`. Expect `{a, b} = 00, 01, 10, 11`, `err = 0` each cycle, and `ok_cnt = 4`.
2. **Invalid codes:** send `y = 0000`, `1010`, `1111`. Expect `{a, b}` of `00` with `err = 1`, `11` with `err = 1`, and `11` with `err = 1`; expect `err_cnt = 3` and `ok_cnt` unchanged.
3. **Backpressure:**
   - Accept `0100`, then hold `out_ready = 0` for 5 cycles while `y_valid = 1` with `y = 0001`. Expect `y_ready = 0`, `{a, b}` held at `10`, and no counter change.
   - Then raise `out_ready`. Expect `00` on the next cycle.
4. **Saturation:** with `CNT_W = 2`, accept 6 valid codes. Expect `ok_cnt` to step `1, 2, 3, 3, 3, 3`.
5. **Reset mid-operation:** with `FULL` holding `11` and `out_ready = 0`, assert `rst` for one cycle. Expect `out_valid = 0`, both counters 0, and `y_ready = 1` on the following cycle; the result `11` is never delivered.
6. **Bubble:** alternate `y_valid` `1, 0, 1` with `out_ready = 1`. Expect `out_valid` to follow one cycle later as `1, 0, 1`.
